// File: rtl/xor_cipher_pkg.sv
// Shared state encoding and counter sizing helper for the streaming XOR cipher.
package xor_cipher_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_KEY, READY, STREAM} state_t;

  // One spare bit so a counter can hold N without wrapping to zero.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/xor_key_reg.sv
// Stored key plus per-frame working key for the XOR cipher.
// Compile switch XOR_AUTOKEY_EN feeds ciphertext back into the working key instead of plain rotation.
module xor_key_reg
  import xor_cipher_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int KEY_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_shift,
  input  logic             frame_copy,
  input  logic             rotate,
  input  logic             decrypt,
  input  logic [LANES-1:0] data,
  output logic [LANES-1:0] key_lane
);

  logic [KEY_BITS-1:0] stored_key;
  logic [KEY_BITS-1:0] work_key;
  logic [KEY_BITS-1:0] cur_key;
  logic [LANES-1:0]    feedback;

  // The first beat of a frame uses the stored key directly while it is copied in.
  always_comb begin
    cur_key  = frame_copy ? stored_key : work_key;
    key_lane = cur_key[KEY_BITS-1 -: LANES];
  end

`ifdef XOR_AUTOKEY_EN
  // Incoming data is already ciphertext when decrypting, so both directions feed back ciphertext.
  assign feedback = decrypt ? data : (data ^ key_lane);
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  assign feedback       = key_lane;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stored_key <= '0;
      work_key   <= '0;
    end else begin
      if (load_shift) stored_key <= (stored_key << LANES) | KEY_BITS'(data);
      if (rotate)     work_key   <= (cur_key << LANES) | KEY_BITS'(feedback);
    end
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: key/message beats in, ciphertext one cycle later with frame flags.
// Compile switch XOR_AUTOKEY_EN enables ciphertext autokey feedback into the working key.
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int KEY_BITS = 32,
  parameter int MSG_BITS = 512
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [LANES-1:0] iData,
  input  logic             iLoad_key,
  input  logic             iLoad_msg,
  input  logic             iDecrypt,
  output logic [LANES-1:0] oData,
  output logic             oValid,
  output logic             oStart,
  output logic             oEnd,
  output logic             oKey_ready,
  output logic             oAbort,
  output logic             oErr
);

  localparam int KEY_BEATS = KEY_BITS / LANES;
  localparam int MSG_BEATS = MSG_BITS / LANES;
  localparam int KCW       = cnt_w(KEY_BEATS);
  localparam int MCW       = cnt_w(MSG_BEATS);
  localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_BEATS - 1);
  localparam logic [MCW-1:0] MSG_LAST = MCW'(MSG_BEATS - 1);

  if (KEY_BITS % LANES != 0) begin : g_key_chk
    $error("KEY_BITS must be a multiple of LANES");
  end
  if (MSG_BITS % LANES != 0) begin : g_msg_chk
    $error("MSG_BITS must be a multiple of LANES");
  end

  state_t           state, state_n;
  logic [KCW-1:0]   key_cnt, key_idx;
  logic [MCW-1:0]   msg_cnt, msg_idx;
  logic             key_beat, msg_req, msg_beat, collide, abort;
  logic             key_first, key_done, first_beat, last_beat;
  logic             dec_sel;
  logic [LANES-1:0] key_lane;

  // A key beat always wins; a message beat is only usable once a key is complete.
  always_comb begin
    key_beat   = iEn & iLoad_key;
    msg_req    = iEn & iLoad_msg;
    msg_beat   = msg_req & ~iLoad_key & ((state == READY) | (state == STREAM));
    collide    = msg_req & (iLoad_key | (state == IDLE) | (state == LOAD_KEY));
    key_first  = key_beat & (state != LOAD_KEY);
    first_beat = msg_beat & (state == READY);
    key_idx    = key_first ? '0 : key_cnt;
    msg_idx    = first_beat ? '0 : msg_cnt;
    key_done   = key_beat & (key_idx == KEY_LAST);
    last_beat  = msg_beat & (msg_idx == MSG_LAST);
    abort      = key_beat & (state == STREAM);
  end

  always_comb begin
    state_n = state;
    if (key_beat)      state_n = key_done ? READY : LOAD_KEY;
    else if (msg_beat) state_n = last_beat ? READY : STREAM;
  end

`ifdef XOR_AUTOKEY_EN
  logic dec_q;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)            dec_q <= 1'b0;
    else if (first_beat) dec_q <= iDecrypt;
  end
  assign dec_sel = first_beat ? iDecrypt : dec_q;
`else
  logic unused_decrypt;
  assign unused_decrypt = iDecrypt;
  assign dec_sel        = 1'b0;
`endif

  xor_key_reg #(
    .LANES    (LANES),
    .KEY_BITS (KEY_BITS)
  ) u_key_reg (
    .clk        (iClk),
    .rst        (iRst),
    .load_shift (key_beat),
    .frame_copy (first_beat),
    .rotate     (msg_beat),
    .decrypt    (dec_sel),
    .data       (iData),
    .key_lane   (key_lane)
  );

  // Pulse outputs are rebuilt every cycle, so a stalled cycle drives them low.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      key_cnt    <= '0;
      msg_cnt    <= '0;
      oData      <= '0;
      oValid     <= 1'b0;
      oStart     <= 1'b0;
      oEnd       <= 1'b0;
      oKey_ready <= 1'b0;
      oAbort     <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      state  <= state_n;
      oValid <= msg_beat;
      oStart <= first_beat;
      oEnd   <= last_beat;
      oAbort <= abort;
      oErr   <= oErr | collide;
      if (key_beat) begin
        key_cnt    <= key_done ? '0 : key_idx + KCW'(1);
        oKey_ready <= key_done;
        msg_cnt    <= '0;
      end else if (msg_beat) begin
        msg_cnt <= last_beat ? '0 : msg_idx + MCW'(1);
      end
      if (msg_beat) oData <= iData ^ key_lane;
    end
  end

endmodule
